// File: rtl/iob_pulse_req_pkg.sv
// Shared types and helpers for the pulse-to-handshake bridge (iob_pulse_req)
// and its edge-detect stage.
package iob_pulse_req_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_GAP  = 2'd2
    } state_e;

    // The timer must reach TIMEOUT-1 while in REQ and GAP-1 while in GAP.
    function automatic int timer_width(input int timeout, input int gap);
        int m;
        m = (timeout > gap) ? timeout : gap;
        return $clog2(m + 1);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] maxv;
        maxv = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= maxv) ? maxv : v + 32'd1;
    endfunction

endpackage

// File: rtl/iob_edge_det.sv
// Registered rising-edge detector: rise_o is high for the first cycle d_i is
// seen high after being low. A level held high produces a single rise.
module iob_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_o
);

    logic pulse_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= d_i;
        end
    end

    assign rise_o = d_i & ~pulse_q;

endmodule

// File: rtl/iob_pulse_req.sv
// Turns each rising edge of pulse_in into a req/ack handshake, then re-arms the
// upstream generator with restart_o after GAP cycles. Optional event counters
// are enabled by defining IOB_PULSE_REQ_CNT_EN.
module iob_pulse_req #(
    parameter int TIMEOUT = 16,
    parameter int GAP     = 4,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic pulse_in,
    input  logic ack_i,
    output logic req_o,
    output logic restart_o,
    output logic busy_o,
    output logic timeout_o,
    output logic overrun_o
`ifdef IOB_PULSE_REQ_CNT_EN
    ,
    output logic [CNT_W-1:0] ok_cnt_o,
    output logic [CNT_W-1:0] drop_cnt_o
`endif
);

    import iob_pulse_req_pkg::*;

    localparam int TW       = timer_width(TIMEOUT, GAP);
    localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          req_q, req_d;
    logic          restart_q, restart_d;
    logic          timeout_q, timeout_d;
    logic          overrun_q, overrun_d;
    logic          rise;

    iob_edge_det u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (pulse_in),
        .rise_o (rise)
    );

    // en low overrides everything: back to IDLE silently, no strobes.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        req_d     = req_q;
        restart_d = 1'b0;
        timeout_d = 1'b0;
        overrun_d = overrun_q;
        if (!en) begin
            state_d   = S_IDLE;
            timer_d   = '0;
            req_d     = 1'b0;
            overrun_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rise) begin
                        state_d = S_REQ;
                        req_d   = 1'b1;
                        timer_d = '0;
                    end
                end
                S_REQ: begin
                    if (rise) begin
                        overrun_d = 1'b1;
                    end
                    if (ack_i || (timer_q == TW'(TIMEOUT - 1))) begin
                        req_d     = 1'b0;
                        timer_d   = '0;
                        timeout_d = ~ack_i;
                        if (GAP == 0) begin
                            restart_d = 1'b1;
                            state_d   = S_IDLE;
                        end else begin
                            state_d   = S_GAP;
                        end
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                S_GAP: begin
                    if (rise) begin
                        overrun_d = 1'b1;
                    end
                    if (timer_q == TW'(GAP_LAST)) begin
                        restart_d = 1'b1;
                        state_d   = S_IDLE;
                        timer_d   = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    timer_d = '0;
                    req_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            req_q     <= 1'b0;
            restart_q <= 1'b0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            req_q     <= req_d;
            restart_q <= restart_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
        end
    end

    assign req_o     = req_q;
    assign restart_o = restart_q;
    assign timeout_o = timeout_q;
    assign overrun_o = overrun_q;
    assign busy_o    = (state_q != S_IDLE);

`ifdef IOB_PULSE_REQ_CNT_EN
    logic [CNT_W-1:0] ok_cnt_q, ok_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             ack_done, overrun_evt;

    // A timeout and a dropped edge on the same cycle are two separate drops.
    always_comb begin
        ack_done    = en && (state_q == S_REQ) && ack_i;
        overrun_evt = en && rise && (state_q != S_IDLE);
        ok_cnt_d    = ok_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (!en) begin
            ok_cnt_d   = '0;
            drop_cnt_d = '0;
        end else begin
            if (ack_done) begin
                ok_cnt_d = CNT_W'(sat_inc(32'(ok_cnt_q), CNT_W));
            end
            if (overrun_evt) begin
                drop_cnt_d = CNT_W'(sat_inc(32'(drop_cnt_d), CNT_W));
            end
            if (timeout_d) begin
                drop_cnt_d = CNT_W'(sat_inc(32'(drop_cnt_d), CNT_W));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ok_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            ok_cnt_q   <= ok_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign ok_cnt_o   = ok_cnt_q;
    assign drop_cnt_o = drop_cnt_q;
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_iob_pulse_req.sv
// Self-checking bench for iob_pulse_req: directed scenarios plus randomized
// traffic checked against an event-timeline reference model.
module tb_iob_pulse_req;

    localparam int TIMEOUT = 16;
    localparam int GAP     = 4;
    localparam int CNT_W   = 8;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic en, pulse_in, ack_i;
    logic req_o, restart_o, busy_o, timeout_o, overrun_o;
    logic en2, pulse2, ack2;
    logic req2, restart2, busy2, timeout2, overrun2;
`ifdef IOB_PULSE_REQ_CNT_EN
    logic [CNT_W-1:0] okCnt, dropCnt;
    logic [1:0]       okCnt2, dropCnt2;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    iob_pulse_req #(.TIMEOUT(TIMEOUT), .GAP(GAP), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .pulse_in(pulse_in), .ack_i(ack_i),
        .req_o(req_o), .restart_o(restart_o), .busy_o(busy_o),
        .timeout_o(timeout_o), .overrun_o(overrun_o)
`ifdef IOB_PULSE_REQ_CNT_EN
        , .ok_cnt_o(okCnt), .drop_cnt_o(dropCnt)
`endif
    );

    // Second instance exercises the GAP==0 path and tiny saturating counters.
    iob_pulse_req #(.TIMEOUT(4), .GAP(0), .CNT_W(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en2), .pulse_in(pulse2), .ack_i(ack2),
        .req_o(req2), .restart_o(restart2), .busy_o(busy2),
        .timeout_o(timeout2), .overrun_o(overrun2)
`ifdef IOB_PULSE_REQ_CNT_EN
        , .ok_cnt_o(okCnt2), .drop_cnt_o(dropCnt2)
`endif
    );

    // Reference model: tracks absolute edge numbers of the deadline and the
    // restart instead of a running timer.
    int   edgeN, mDeadline, mRestartEdge, mOk, mDrop;
    logic mBusy, mInReq, mReq, mRestart, mTimeout, mOverrun, mPrev;

    task automatic model_reset();
        edgeN = 0; mDeadline = 0; mRestartEdge = 0; mOk = 0; mDrop = 0;
        mBusy = 0; mInReq = 0; mReq = 0; mRestart = 0; mTimeout = 0;
        mOverrun = 0; mPrev = 0;
    endtask

    task automatic model_edge();
        logic rise;
        edgeN++;
        rise = pulse_in && !mPrev;
        mPrev = pulse_in;
        mRestart = 0;
        mTimeout = 0;
        if (!en) begin
            mBusy = 0; mInReq = 0; mReq = 0; mOverrun = 0; mOk = 0; mDrop = 0;
        end else if (!mBusy) begin
            if (rise) begin
                mBusy = 1; mInReq = 1; mReq = 1; mDeadline = edgeN + TIMEOUT;
            end
        end else begin
            if (rise) begin
                mOverrun = 1;
                mDrop = (mDrop < CMAX) ? mDrop + 1 : CMAX;
            end
            if (mInReq) begin
                if (ack_i || edgeN == mDeadline) begin
                    mReq = 0; mInReq = 0; mTimeout = !ack_i;
                    if (ack_i) mOk = (mOk < CMAX) ? mOk + 1 : CMAX;
                    else       mDrop = (mDrop < CMAX) ? mDrop + 1 : CMAX;
                    mRestartEdge = edgeN + GAP;
                    if (GAP == 0) begin
                        mRestart = 1; mBusy = 0;
                    end
                end
            end else if (edgeN == mRestartEdge) begin
                mRestart = 1; mBusy = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0; en = 0; pulse_in = 0; ack_i = 0; en2 = 0; pulse2 = 0; ack2 = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 0; en = 1; pulse_in = 0; ack_i = 0; en2 = 1; pulse2 = 0; ack2 = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({req_o, restart_o, busy_o, timeout_o, overrun_o} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b want 00000",
                     {req_o, restart_o, busy_o, timeout_o, overrun_o});
        end
        checks++;
        if ({req2, restart2, busy2, timeout2, overrun2} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs_gap0: got %b want 00000",
                     {req2, restart2, busy2, timeout2, overrun2});
        end
`ifdef IOB_PULSE_REQ_CNT_EN
        checks++;
        if (okCnt !== '0 || dropCnt !== '0) begin
            errors++;
            $display("[TB] FAIL reset_counters: got ok=%0d drop=%0d want 0 0", okCnt, dropCnt);
        end
`endif
        rst_n = 1;
        model_reset();
    endtask

    task automatic test_basic();
        do_reset();
        en = 1;
        repeat (2) step();
        pulse_in = 1;
        step();
        checks++;
        if (req_o !== 1'b1 || busy_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_req_start: got req=%b busy=%b want 1 1", req_o, busy_o);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (req_o !== 1'b1) begin
                errors++;
                $display("[TB] FAIL basic_req_hold[%0d]: got %b want 1", i, req_o);
            end
        end
        ack_i = 1;
        step();
        ack_i = 0;
        checks++;
        if (req_o !== 1'b0 || busy_o !== 1'b1 || timeout_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_ack_drop: got req=%b busy=%b to=%b want 0 1 0",
                     req_o, busy_o, timeout_o);
        end
        for (int i = 0; i < GAP - 1; i++) begin
            step();
            checks++;
            if (restart_o !== 1'b0 || busy_o !== 1'b1) begin
                errors++;
                $display("[TB] FAIL basic_gap[%0d]: got restart=%b busy=%b want 0 1",
                         i, restart_o, busy_o);
            end
        end
        step();
        checks++;
        if (restart_o !== 1'b1 || busy_o !== 1'b0 || overrun_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_restart: got restart=%b busy=%b ovr=%b want 1 0 0",
                     restart_o, busy_o, overrun_o);
        end
        step();
        checks++;
        if (restart_o !== 1'b0 || req_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_after: got restart=%b req=%b want 0 0", restart_o, req_o);
        end
    endtask

    task automatic test_timeout();
        int reqCycles, toCount, toIdx, rsIdx, overlap;
        reqCycles = 1; toCount = 0; toIdx = -1; rsIdx = -1; overlap = 0;
        pulse_in = 0;
        step();
        pulse_in = 1;
        step();
        for (int i = 1; i <= 40; i++) begin
            step();
            if (req_o) reqCycles++;
            if (timeout_o) begin toCount++; toIdx = i; end
            if (restart_o) rsIdx = i;
            if (req_o && timeout_o) overlap++;
        end
        checks++;
        if (reqCycles != TIMEOUT) begin
            errors++;
            $display("[TB] FAIL timeout_req_len: got %0d want %0d", reqCycles, TIMEOUT);
        end
        checks++;
        if (toCount != 1 || toIdx != TIMEOUT) begin
            errors++;
            $display("[TB] FAIL timeout_strobe: got count=%0d at %0d want 1 at %0d",
                     toCount, toIdx, TIMEOUT);
        end
        checks++;
        if (rsIdx != TIMEOUT + GAP || overlap != 0) begin
            errors++;
            $display("[TB] FAIL timeout_restart: got at %0d overlap=%0d want at %0d overlap=0",
                     rsIdx, overlap, TIMEOUT + GAP);
        end
    endtask

    task automatic test_gap0_collision();
        en2 = 1;
        pulse2 = 1;
        step();
        pulse2 = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (req2 !== 1'b1 || restart2 !== 1'b0 || timeout2 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL gap0_hold[%0d]: got req=%b rs=%b to=%b want 1 0 0",
                         i, req2, restart2, timeout2);
            end
        end
        ack2 = 1;
        step();
        ack2 = 0;
        checks++;
        if ({req2, timeout2, restart2, busy2} !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL gap0_collision: got req/to/rs/busy=%b want 0010",
                     {req2, timeout2, restart2, busy2});
        end
        step();
        checks++;
        if (restart2 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL gap0_restart_strobe: got %b want 0", restart2);
        end
        pulse2 = 1;
        step();
        pulse2 = 0;
        repeat (3) step();
        step();
        checks++;
        if ({req2, timeout2, restart2, busy2} !== 4'b0110) begin
            errors++;
            $display("[TB] FAIL gap0_timeout: got req/to/rs/busy=%b want 0110",
                     {req2, timeout2, restart2, busy2});
        end
        step();
        checks++;
        if (timeout2 !== 1'b0 || restart2 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL gap0_timeout_strobe: got to=%b rs=%b want 0 0", timeout2, restart2);
        end
    endtask

    task automatic test_overrun_en();
        pulse_in = 0;
        step();
        pulse_in = 1;
        step();
        ack_i = 1;
        step();
        ack_i = 0;
        pulse_in = 0;
        step();
        pulse_in = 1;
        step();
        checks++;
        if (overrun_o !== 1'b1 || req_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overrun_set: got ovr=%b req=%b busy=%b want 1 0 1",
                     overrun_o, req_o, busy_o);
        end
        en = 0;
        step();
        en = 1;
        checks++;
        if ({busy_o, overrun_o, restart_o, req_o} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL en_low_clear: got busy/ovr/rs/req=%b want 0000",
                     {busy_o, overrun_o, restart_o, req_o});
        end
        for (int i = 0; i < GAP + 2; i++) begin
            step();
            checks++;
            if (restart_o !== 1'b0 || req_o !== 1'b0) begin
                errors++;
                $display("[TB] FAIL en_no_restart[%0d]: got rs=%b req=%b want 0 0",
                         i, restart_o, req_o);
            end
        end
    endtask

    task automatic test_reset_mid();
        int reqCycles;
        pulse_in = 0;
        step();
        pulse_in = 1;
        step();
        step();
        #2;
        rst_n = 0;
        #1;
        checks++;
        if (req_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_async: got req=%b busy=%b want 0 0", req_o, busy_o);
        end
        pulse_in = 0;
        @(posedge clk);
        #1;
        checks++;
        if (restart_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_no_restart: got %b want 0", restart_o);
        end
        rst_n = 1;
        model_reset();
        step();
        pulse_in = 1;
        step();
        reqCycles = req_o ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (req_o) reqCycles++;
        end
        checks++;
        if (reqCycles != TIMEOUT) begin
            errors++;
            $display("[TB] FAIL reset_fresh_timer: got req for %0d cycles want %0d",
                     reqCycles, TIMEOUT);
        end
    endtask

    task automatic test_random();
        int ackDiv;
        logic [4:0] got, want;
        do_reset();
        en = 1;
        ackDiv = 3;
        for (int i = 0; i < 1200; i++) begin
            if (i % 150 == 0) ackDiv = (ackDiv == 3) ? 25 : 3;
            en = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 3) == 0) pulse_in = ~pulse_in;
            ack_i = ($urandom_range(0, ackDiv - 1) == 0);
            step();
            got  = {req_o, restart_o, busy_o, timeout_o, overrun_o};
            want = {mReq, mRestart, mBusy, mTimeout, mOverrun};
            checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL random_outputs cycle %0d: got req/rs/busy/to/ovr=%b want %b",
                         i, got, want);
            end
`ifdef IOB_PULSE_REQ_CNT_EN
            checks++;
            if (okCnt !== CNT_W'(mOk) || dropCnt !== CNT_W'(mDrop)) begin
                errors++;
                $display("[TB] FAIL random_counters cycle %0d: got ok=%0d drop=%0d want %0d %0d",
                         i, okCnt, dropCnt, mOk, mDrop);
            end
`endif
        end
        ack_i = 0;
    endtask

`ifdef IOB_PULSE_REQ_CNT_EN
    task automatic test_counters();
        en2 = 0; pulse2 = 0; ack2 = 0;
        step();
        checks++;
        if (okCnt2 !== 2'd0 || dropCnt2 !== 2'd0) begin
            errors++;
            $display("[TB] FAIL cnt_en_clear: got ok=%0d drop=%0d want 0 0", okCnt2, dropCnt2);
        end
        en2 = 1;
        for (int i = 0; i < 5; i++) begin
            pulse2 = 1;
            step();
            pulse2 = 0;
            ack2 = 1;
            step();
            ack2 = 0;
            step();
        end
        checks++;
        if (okCnt2 !== 2'd3) begin
            errors++;
            $display("[TB] FAIL cnt_ok_saturate: got %0d want 3", okCnt2);
        end
        pulse2 = 1;
        step();
        pulse2 = 0;
        repeat (4) step();
        pulse2 = 1;
        step();
        pulse2 = 0;
        step();
        pulse2 = 1;
        step();
        ack2 = 1;
        step();
        ack2 = 0;
        pulse2 = 0;
        checks++;
        if (dropCnt2 !== 2'd2 || okCnt2 !== 2'd3) begin
            errors++;
            $display("[TB] FAIL cnt_drop: got drop=%0d ok=%0d want 2 3", dropCnt2, okCnt2);
        end
        en2 = 0;
        step();
        checks++;
        if (okCnt2 !== 2'd0 || dropCnt2 !== 2'd0) begin
            errors++;
            $display("[TB] FAIL cnt_en_low: got ok=%0d drop=%0d want 0 0", okCnt2, dropCnt2);
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_timeout();
        test_gap0_collision();
        test_overrun_en();
        test_reset_mid();
`ifdef IOB_PULSE_REQ_CNT_EN
        test_counters();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
